// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole round scheduler.
//   state_e        : scheduler states
//   DEF_*          : default timing constants (overridable by top parameters)
//   *_W            : counter widths
//   reduce_up_ms() : adaptive up-time step with floor
package whack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOLE_UP   = 2'd1,
    ST_MOLE_DOWN = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  localparam int DEF_CLK_PER_MS          = 50000;
  localparam int DEF_GAME_LENGTH_SECONDS = 20;
  localparam int DEF_MOLE_UP_MS          = 1000;
  localparam int DEF_MOLE_DOWN_MS        = 1000;
  localparam int DEF_MIN_UP_MS           = 300;
  localparam int DEF_STEP_MS             = 50;

  localparam int MS_PER_SEC = 1000;

  localparam int DIV_W   = 20;  // ms divider, covers CLK_PER_MS up to ~1M
  localparam int PHASE_W = 16;  // phase length counter and up_ms
  localparam int MSEC_W  = 10;  // ms within the current second (0..999)
  localparam int SEC_W   = 7;   // seconds_left
  localparam int ROUND_W = 8;   // round_count

  // Shorten the up time by one step, never going below the floor.
  function automatic logic [PHASE_W-1:0] reduce_up_ms(
    input logic [PHASE_W-1:0] cur,
    input logic [PHASE_W-1:0] step,
    input logic [PHASE_W-1:0] floor_ms
  );
    if (cur < floor_ms + step) return floor_ms;
    return cur - step;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick divider.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronously restart the divider
//   enable     : count while high
//   tick       : one-cycle pulse every CLK_PER_MS enabled clocks
module ms_tick_gen #(
  parameter int CLK_PER_MS = 50000,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q;

  assign tick = enable && !clear && (cnt_q == CNT_W'(CLK_PER_MS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round scheduler: alternates mole-visible / gap phases for a
// fixed game length and counts down remaining seconds.
//   clk, rst_n        : clock, async active-low reset
//   start_pressed     : start a game from IDLE or GAME_OVER
//   reset_pressed     : soft reset to IDLE from any state (beats start)
//   full_clear_hit    : all visible moles hit, ends MOLE_UP early
//   game_in_progress  : MOLE_UP or MOLE_DOWN
//   mole_clk          : one-cycle pulse on every MOLE_UP entry
//   moles_visible     : MOLE_UP
//   seconds_left      : remaining seconds
//   round_count       : rounds started this game, saturating
//   game_over         : GAME_OVER
// Build option: define ADAPTIVE_SPEED_EN to shrink the up time by STEP_MS on
// every accepted full clear (floored at MIN_UP_MS).
//
// state        | meaning
// IDLE         | waiting for start, everything cleared
// MOLE_UP      | moles visible for up_ms
// MOLE_DOWN    | gap for MOLE_DOWN_MS
// GAME_OVER    | time expired, score held until start/reset
module mole_round_scheduler
  import whack_pkg::*;
#(
  parameter int CLK_PER_MS          = DEF_CLK_PER_MS,
  parameter int GAME_LENGTH_SECONDS = DEF_GAME_LENGTH_SECONDS,
  parameter int MOLE_UP_MS          = DEF_MOLE_UP_MS,
  parameter int MOLE_DOWN_MS        = DEF_MOLE_DOWN_MS,
  parameter int MIN_UP_MS           = DEF_MIN_UP_MS,
  parameter int STEP_MS             = DEF_STEP_MS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_pressed,
  input  logic               reset_pressed,
  input  logic               full_clear_hit,
  output logic               game_in_progress,
  output logic               mole_clk,
  output logic               moles_visible,
  output logic [SEC_W-1:0]   seconds_left,
  output logic [ROUND_W-1:0] round_count,
  output logic               game_over
);

`ifdef ADAPTIVE_SPEED_EN
  localparam bit ADAPT_EN = 1'b1;
`else
  localparam bit ADAPT_EN = 1'b0;
`endif

  state_e               state_q;
  logic                 mole_clk_q;
  logic [SEC_W-1:0]     sec_q;
  logic [ROUND_W-1:0]   round_q;
  logic [PHASE_W-1:0]   phase_q;
  logic [PHASE_W-1:0]   up_ms_q;
  logic [MSEC_W-1:0]    msec_q;

  logic                 in_play;
  logic                 ms_tick;
  logic                 div_clear;
  logic [PHASE_W-1:0]   phase_limit;
  logic                 phase_done;
  logic                 sec_done;

  assign in_play   = (state_q == ST_MOLE_UP) || (state_q == ST_MOLE_DOWN);
  // Divider idles at zero outside play so the first tick lands exactly
  // CLK_PER_MS clocks after the start edge.
  assign div_clear = !in_play || reset_pressed;

  ms_tick_gen #(
    .CLK_PER_MS(CLK_PER_MS),
    .CNT_W     (DIV_W)
  ) u_ms_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (div_clear),
    .enable(in_play),
    .tick  (ms_tick)
  );

  assign phase_limit = (state_q == ST_MOLE_UP) ? up_ms_q : PHASE_W'(MOLE_DOWN_MS);
  assign phase_done  = ms_tick && (phase_q == phase_limit - PHASE_W'(1));
  // Last ms of the last second: time-out wins over any phase change.
  assign sec_done    = ms_tick && (msec_q == MSEC_W'(MS_PER_SEC - 1)) &&
                       (sec_q == SEC_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mole_clk_q <= 1'b0;
      sec_q      <= '0;
      round_q    <= '0;
      phase_q    <= '0;
      msec_q     <= '0;
      up_ms_q    <= PHASE_W'(MOLE_UP_MS);
    end else begin
      mole_clk_q <= 1'b0;
      if (reset_pressed) begin
        state_q <= ST_IDLE;
        sec_q   <= '0;
        round_q <= '0;
        phase_q <= '0;
        msec_q  <= '0;
        up_ms_q <= PHASE_W'(MOLE_UP_MS);
      end else begin
        case (state_q)
          ST_IDLE, ST_GAME_OVER: begin
            if (start_pressed) begin
              state_q    <= ST_MOLE_UP;
              mole_clk_q <= 1'b1;
              sec_q      <= SEC_W'(GAME_LENGTH_SECONDS);
              round_q    <= ROUND_W'(1);
              phase_q    <= '0;
              msec_q     <= '0;
              up_ms_q    <= PHASE_W'(MOLE_UP_MS);
            end
          end
          ST_MOLE_UP, ST_MOLE_DOWN: begin
            if (ms_tick) begin
              phase_q <= phase_q + PHASE_W'(1);
              if (msec_q == MSEC_W'(MS_PER_SEC - 1)) begin
                msec_q <= '0;
                sec_q  <= sec_q - SEC_W'(1);
              end else begin
                msec_q <= msec_q + MSEC_W'(1);
              end
            end
            if (sec_done) begin
              state_q <= ST_GAME_OVER;
              phase_q <= '0;
            end else if (state_q == ST_MOLE_UP && (full_clear_hit || phase_done)) begin
              state_q <= ST_MOLE_DOWN;
              phase_q <= '0;
              if (ADAPT_EN && full_clear_hit) begin
                up_ms_q <= reduce_up_ms(up_ms_q, PHASE_W'(STEP_MS), PHASE_W'(MIN_UP_MS));
              end
            end else if (state_q == ST_MOLE_DOWN && phase_done) begin
              state_q    <= ST_MOLE_UP;
              phase_q    <= '0;
              mole_clk_q <= 1'b1;
              if (round_q != '1) round_q <= round_q + ROUND_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign game_in_progress = in_play;
  assign moles_visible    = (state_q == ST_MOLE_UP);
  assign game_over        = (state_q == ST_GAME_OVER);
  assign mole_clk         = mole_clk_q;
  assign seconds_left     = sec_q;
  assign round_count      = round_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
module tb_mole_round_scheduler;

  localparam int C      = 4;
  localparam int G      = 2;
  localparam int UPMS   = 5;
  localparam int DNMS   = 3;
  localparam int MINMS  = 3;
  localparam int STEPMS = 1;
`ifdef ADAPTIVE_SPEED_EN
  localparam bit ADAPT = 1'b1;
`else
  localparam bit ADAPT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_pressed = 1'b0;
  logic       reset_pressed = 1'b0;
  logic       full_clear_hit = 1'b0;
  logic       game_in_progress, mole_clk, moles_visible, game_over;
  logic [6:0] seconds_left;
  logic [7:0] round_count;

  int n_tests = 0;
  int n_fail  = 0;

  mole_round_scheduler #(
    .CLK_PER_MS(C), .GAME_LENGTH_SECONDS(G), .MOLE_UP_MS(UPMS),
    .MOLE_DOWN_MS(DNMS), .MIN_UP_MS(MINMS), .STEP_MS(STEPMS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_pressed(start_pressed),
    .reset_pressed(reset_pressed), .full_clear_hit(full_clear_hit),
    .game_in_progress(game_in_progress), .mole_clk(mole_clk),
    .moles_visible(moles_visible), .seconds_left(seconds_left),
    .round_count(round_count), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model: absolute-time view of a game. Time t counts clocks since
  // the start edge; ms boundaries are multiples of C; each phase ends at an
  // absolute ms value fixed when the phase is entered.
  int m_st;     // 0 idle, 1 up, 2 down, 3 over
  int m_t, m_end, m_up, m_rounds, m_secs;
  bit m_mc;

  function automatic void model_reset();
    m_st = 0; m_t = 0; m_end = 0; m_up = UPMS; m_rounds = 0; m_secs = 0; m_mc = 0;
  endfunction

  function automatic void model_step(input bit s, input bit r, input bit h);
    int ms;
    bit tk;
    m_mc = 0;
    if (r) begin
      model_reset();
    end else if (m_st == 0 || m_st == 3) begin
      if (s) begin
        m_st = 1; m_t = 0; m_end = UPMS; m_up = UPMS; m_rounds = 1; m_secs = G; m_mc = 1;
      end
    end else begin
      m_t++;
      ms = m_t / C;
      tk = (m_t % C) == 0;
      m_secs = G - ms / 1000;
      if (tk && ms == G * 1000) begin
        m_st = 3; m_secs = 0;
      end else if (m_st == 1 && (h || (tk && ms == m_end))) begin
        m_st = 2; m_end = ms + DNMS;
        if (h && ADAPT) m_up = (m_up - STEPMS < MINMS) ? MINMS : m_up - STEPMS;
      end else if (m_st == 2 && tk && ms == m_end) begin
        m_st = 1; m_end = ms + m_up; m_mc = 1;
        if (m_rounds < 255) m_rounds++;
      end
    end
  endfunction

  function automatic logic [17:0] pack(input bit gip, input bit mc, input bit vis,
                                       input int sec, input int rnd, input bit ov);
    logic [6:0] s7;
    logic [7:0] r8;
    s7 = sec[6:0];
    r8 = rnd[7:0];
    return {gip, mc, vis, s7, r8, ov};
  endfunction

  function automatic logic [17:0] dut_out();
    return {game_in_progress, mole_clk, moles_visible, seconds_left, round_count, game_over};
  endfunction

  function automatic logic [17:0] model_out();
    return pack(m_st == 1 || m_st == 2, m_mc, m_st == 1, m_secs, m_rounds, m_st == 3);
  endfunction

  task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got gip/mc/vis/sec/rnd/ov=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input bit s, input bit r, input bit h);
    start_pressed = s; reset_pressed = r; full_clear_hit = h;
    @(posedge clk);
    model_step(s, r, h);
    #1;
    start_pressed = 1'b0; reset_pressed = 1'b0; full_clear_hit = 1'b0;
  endtask

  task automatic wait_vis(input logic v, input string nm);
    int b = 0;
    while (moles_visible !== v && b < 200) begin
      tick(0, 0, 0);
      b++;
    end
    if (moles_visible !== v) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timed out waiting for moles_visible=%0b", nm, v);
    end
  endtask

  task automatic measure_up(output int len);
    len = 0;
    while (moles_visible === 1'b1 && len < 100) begin
      len++;
      tick(0, 0, 0);
    end
  endtask

  typedef struct {
    bit s, r, h;
    int n;
    bit gip, mc, vis;
    int sec, rnd;
    bit ov;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int pulses;
    int len;
    int exp_len;

    // s r h  n   gip mc vis sec rnd ov
    tbl.push_back('{1, 0, 0, 1,  1, 1, 1, 2, 1, 0});  // start from IDLE
    tbl.push_back('{0, 0, 0, 1,  1, 0, 1, 2, 1, 0});
    tbl.push_back('{0, 0, 0, 18, 1, 0, 1, 2, 1, 0});  // last up clock (20th)
    tbl.push_back('{0, 0, 0, 1,  1, 0, 0, 2, 1, 0});  // down after 20 clocks
    tbl.push_back('{0, 0, 0, 11, 1, 0, 0, 2, 1, 0});  // last down clock (12th)
    tbl.push_back('{0, 0, 0, 1,  1, 1, 1, 2, 2, 0});  // second round
    tbl.push_back('{1, 0, 0, 1,  1, 0, 1, 2, 2, 0});  // start ignored in play
    tbl.push_back('{0, 0, 0, 20, 1, 0, 0, 2, 2, 0});  // into MOLE_DOWN
    tbl.push_back('{1, 1, 0, 1,  0, 0, 0, 0, 0, 0});  // reset beats start
    tbl.push_back('{0, 0, 0, 1,  0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 1,  0, 0, 0, 0, 0, 0});  // hit ignored in IDLE
    tbl.push_back('{1, 0, 0, 1,  1, 1, 1, 2, 1, 0});
    tbl.push_back('{0, 0, 0, 2,  1, 0, 1, 2, 1, 0});
    tbl.push_back('{0, 0, 1, 1,  1, 0, 0, 2, 1, 0});  // full clear ends up early
    tbl.push_back('{0, 0, 0, 1,  1, 0, 0, 2, 1, 0});
    tbl.push_back('{0, 0, 0, 8,  1, 1, 1, 2, 2, 0});  // down ends at ms 3

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_out(), pack(0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick(0, 0, 0);
    check("idle_after_release", dut_out(), pack(0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      tick(tbl[i].s, tbl[i].r, tbl[i].h);
      for (int k = 1; k < tbl[i].n; k++) tick(0, 0, 0);
      check($sformatf("table_row_%0d", i),
            dut_out(), pack(tbl[i].gip, tbl[i].mc, tbl[i].vis, tbl[i].sec, tbl[i].rnd, tbl[i].ov));
    end

    // Full game to time-out: 2 s = 8000 clocks, 250 rounds of 8 ms.
    tick(0, 1, 0);
    tick(1, 0, 0);
    pulses = mole_clk ? 1 : 0;
    for (int i = 1; i < 4000; i++) begin
      tick(0, 0, 0);
      if (mole_clk) pulses++;
    end
    check_int("seconds_before_1s", seconds_left, 2);
    tick(0, 0, 0);
    if (mole_clk) pulses++;
    check_int("seconds_at_1s", seconds_left, 1);
    for (int i = 4001; i < 8000; i++) begin
      tick(0, 0, 0);
      if (mole_clk) pulses++;
    end
    check("just_before_timeout", {game_over, seconds_left}, {1'b0, 7'd1});
    tick(0, 0, 0);
    check("timeout_outputs", dut_out(), pack(0, 0, 0, 0, 250, 1));
    check_int("mole_pulses_in_game", pulses, 250);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 1);
      if (mole_clk) pulses++;
    end
    check_int("no_mole_clk_after_timeout", pulses, 0);
    check("game_over_hold", dut_out(), pack(0, 0, 0, 0, 250, 1));
    tick(1, 0, 0);
    check("restart_from_game_over", dut_out(), pack(1, 1, 1, 2, 1, 0));

    // Async reset in the middle of MOLE_UP.
    repeat (3) tick(0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("async_reset_no_edge", dut_out(), pack(0, 0, 0, 0, 0, 0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(0, 0, 0);
    check("idle_after_async_reset", dut_out(), pack(0, 0, 0, 0, 0, 0));

    // Up-phase lengths after full clears.
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 1);
    wait_vis(1'b1, "adapt_p2_entry");
    measure_up(len);
    exp_len = ADAPT ? 16 : 20;
    check_int("up_len_after_1_clear", len, exp_len);
    wait_vis(1'b1, "adapt_p3_entry");
    tick(0, 0, 1);
    wait_vis(1'b1, "adapt_p4_entry");
    measure_up(len);
    exp_len = ADAPT ? 12 : 20;
    check_int("up_len_after_2_clears", len, exp_len);
    wait_vis(1'b1, "adapt_p5_entry");
    tick(0, 0, 1);
    wait_vis(1'b1, "adapt_p6_entry");
    measure_up(len);
    check_int("up_len_at_floor", len, exp_len);

    // Randomized traffic against the model.
    for (int i = 0; i < 24000; i++) begin
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 19999) == 0, $urandom_range(0, 7) == 0);
      check("random", dut_out(), model_out());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_round_scheduler.md
MOLE_ROUND_SCHEDULER -- requirements
Module: mole_round_scheduler

Interface
REQ-001 Parameter CLK_PER_MS, default 50000, meaning clocks per millisecond tick.
REQ-002 Parameter GAME_LENGTH_SECONDS, default 20, meaning game duration; legal range 1..99.
REQ-003 Parameter MOLE_UP_MS, default 1000, meaning initial mole-visible phase length.
REQ-004 Parameter MOLE_DOWN_MS, default 1000, meaning gap phase length.
REQ-005 Parameter MIN_UP_MS, default 300, meaning floor for adaptive up time.
REQ-006 Parameter STEP_MS, default 50, meaning up-time reduction per full clear.
REQ-007 clk  in  1  system clock; one clock domain; all logic rising-edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 start_pressed  in  1  debounced one-cycle start pulse.
REQ-010 reset_pressed  in  1  debounced one-cycle soft-reset pulse.
REQ-011 full_clear_hit  in  1  one-cycle pulse: all visible moles hit.
REQ-012 game_in_progress  out  1  high in MOLE_UP and MOLE_DOWN.
REQ-013 mole_clk  out  1  one-cycle pulse requesting a new mole set.
REQ-014 moles_visible  out  1  high only in MOLE_UP.
REQ-015 seconds_left  out  7  remaining game seconds.
REQ-016 round_count  out  8  mole rounds started this game, saturating at 255.
REQ-017 game_over  out  1  high only in GAME_OVER.

Function
REQ-018 States SHALL be IDLE, MOLE_UP, MOLE_DOWN, GAME_OVER.
REQ-019 IDLE or GAME_OVER + start_pressed -> MOLE_UP; seconds_left=GAME_LENGTH_SECONDS, round_count=1, up_ms=MOLE_UP_MS, ms divider and phase/second counters cleared.
REQ-020 start_pressed in MOLE_UP/MOLE_DOWN SHALL be ignored.
REQ-021 ms_tick SHALL pulse every CLK_PER_MS clocks while game_in_progress; first pulse CLK_PER_MS clocks after entering play.
REQ-022 Phase counter SHALL clear on each phase entry; phase ends on the ms_tick where count==limit-1, so each phase lasts exactly limit ms.
REQ-023 MOLE_UP -> MOLE_DOWN at up_ms expiry or on full_clear_hit, whichever first.
REQ-024 MOLE_DOWN -> MOLE_UP at MOLE_DOWN_MS expiry; round_count increments (saturating).
REQ-025 mole_clk SHALL assert in the first cycle of every MOLE_UP entry, including game start.
REQ-026 seconds_left SHALL decrement every 1000 ms_ticks; on reaching 0 -> GAME_OVER same cycle.
REQ-027 Time-out SHALL override a coincident phase transition or full_clear_hit; no mole_clk issued.
REQ-028 reset_pressed SHALL force IDLE from any state, clearing all counters; it overrides start_pressed in the same cycle.
REQ-029 full_clear_hit outside MOLE_UP SHALL be ignored.
REQ-030 GAME_OVER SHALL hold seconds_left=0 and round_count until start or reset.

Reset
REQ-031 rst_n low SHALL asynchronously set state=IDLE, all outputs 0, up_ms=MOLE_UP_MS, all counters 0.
REQ-032 Deassertion SHALL be used synchronously; first possible transition is the cycle after release.

Configuration
REQ-033 With ADAPTIVE_SPEED_EN defined, each accepted full_clear_hit SHALL reduce up_ms by STEP_MS, floored at MIN_UP_MS, effective from the next MOLE_UP.
REQ-034 Without ADAPTIVE_SPEED_EN, up_ms SHALL remain MOLE_UP_MS for the whole game; full_clear_hit still ends MOLE_UP early.

Structure
REQ-035 State enum, default timing constants and counter widths SHALL live in shared package whack_pkg.
REQ-036 The ms divider SHALL be sub-module ms_tick_gen (clk, rst_n, clear, enable, tick).

Verification (CLK_PER_MS=4, GAME_LENGTH_SECONDS=2, MOLE_UP_MS=5, MOLE_DOWN_MS=3, MIN_UP_MS=3, STEP_MS=1)
REQ-037 start_pressed from IDLE -> mole_clk one cycle, moles_visible high 20 clocks, low 12 clocks, mole_clk again, round_count=2.
REQ-038 Run 8000 clocks -> seconds_left 2->1->0, game_over=1, game_in_progress=0, no mole_clk after timeout.
REQ-039 full_clear_hit mid MOLE_UP (ADAPTIVE_SPEED_EN) -> MOLE_DOWN next cycle; subsequent up phases 16,12,12 clocks (floor 3 ms).
REQ-040 reset_pressed and start_pressed same cycle in MOLE_DOWN -> IDLE, all outputs 0.
REQ-041 rst_n low mid MOLE_UP -> outputs 0 immediately without clock edge; start_pressed in MOLE_UP ignored.
